systolic_mmul_engine: RTL and testbench
=======================================

SYSTOLIC_MMUL_ENGINE -- requirements
Module: systolic_mmul_engine

Interface
REQ-001 Parameter N, default 4: array dimension (N x N PEs; N activation lanes, N result lanes); legal range 2..16.
REQ-002 Parameter D_W, default 8: activation and weight element width.
REQ-003 Parameter A_W, default 32: accumulator and result element width; must be >= 2*D_W + clog2(N).
REQ-004 Parameter SIGNED, default 1: 1 = two's-complement operands; 0 = unsigned operands.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-008 reuse_w  input  1  sampled with start; 1 = skip weight load and reuse the resident weights.
REQ-009 w_valid  input  1  weight beat valid.
REQ-010 w_ready  output  1  weight beat accepted when w_valid & w_ready.
REQ-011 w_data  input  N*D_W  weight beat; lane i is bits [i*D_W +: D_W].
REQ-012 a_valid  input  1  activation beat valid.
REQ-013 a_ready  output  1  activation beat accepted when a_valid & a_ready.
REQ-014 a_data  input  N*D_W  activation vector; lane i feeds array row i.
REQ-015 a_last  input  1  marks the final activation beat of the job.
REQ-016 r_valid  output  1  result vector valid; no backpressure.
REQ-017 r_data  output  N*A_W  result vector; lane j is column j.
REQ-018 r_last  output  1  high with the result of the a_last beat.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse at job completion.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, STREAM and DRAIN.
REQ-022 IDLE transitions: start&!reuse_w -> LOAD; start&reuse_w&wloaded -> STREAM; start&reuse_w&!wloaded -> LOAD; start low -> stay IDLE.
REQ-023 In LOAD, w_ready SHALL be 1; exactly N beats SHALL be accepted, counted by a weight beat counter that wraps to 0; the Nth acceptance SHALL go to STREAM and set wloaded.
REQ-024 Weight beat k (k = 0..N-1), lane i SHALL reside in PE[i][N-1-k] after loading; weights SHALL be held until the next LOAD or reset.
REQ-025 In STREAM, a_ready SHALL be 1; a beat accepted with a_last=1 SHALL go to DRAIN.
REQ-026 a_ready and w_ready SHALL be 0 in all other states; beats offered then SHALL be ignored.
REQ-027 The pipeline (skew, array, deskew) SHALL advance every cycle; a cycle with no accepted beat SHALL inject all-zero activations and an invalid tag.
REQ-028 A valid/last tag shift register of depth 2N-1 SHALL track beats: the beat accepted in cycle c SHALL produce r_valid=1 in cycle c+2N-1.
REQ-029 r_data lane j SHALL equal sum over i of a[i]*W[i][j], where W[i][j] is the weight in PE[i][j], computed modulo 2^A_W.
REQ-030 Operands SHALL be sign-extended when SIGNED=1 and zero-extended when SIGNED=0.
REQ-031 Results SHALL leave in acceptance order, with bubbles preserved: the r_valid pattern SHALL equal the acceptance pattern delayed by 2N-1 cycles.
REQ-032 r_data SHALL be 0 whenever r_valid=0.
REQ-033 DRAIN SHALL last until the cycle r_last=1; the next cycle SHALL be IDLE with done=1 for exactly one cycle.
REQ-034 start asserted while busy=1 SHALL be ignored and not queued.
REQ-035 The weight path and the compute path SHALL never be active in the same cycle.

Reset
REQ-036 With reset=0 at a rising edge: FSM -> IDLE; all PE weights, partial sums and skew/deskew registers cleared; tag pipe cleared; wloaded=0; weight counter=0.
REQ-037 During and after reset: w_ready, a_ready, r_valid, r_last, busy and done SHALL be 0, and r_data SHALL be 0.
REQ-038 Reset mid-job SHALL abandon the job with no further r_valid and no done pulse.

Verification (N=4, D_W=8, A_W=32, SIGNED=1)
REQ-039 Identity: load beats k=0..3 with lane 3-k = 1 and others 0; stream a=[1,2,3,4] accepted in cycle c -> r_data=[1,2,3,4], r_valid=r_last=1 in cycle c+7, done in cycle c+8.
REQ-040 Signed extreme: all weights -128, a=[-128,-128,-128,-128] -> every lane = 65536; with SIGNED=0, all operands 0x80 -> every lane = 65536.
REQ-041 Bubbles: 5 beats with a_valid pattern 1,0,1,1,0,0,1,1 -> r_valid pattern identical, 7 cycles later; values in order; r_last on the 5th result only.
REQ-042 Reuse: job 1 full load, then start with reuse_w=1 -> busy, FSM straight to STREAM, w_ready never 1, results computed with job 1 weights.
REQ-043 reuse_w=1 after reset -> LOAD entered; start pulsed during STREAM -> no effect.
REQ-044 Reset asserted 2 cycles after the 3rd accepted beat -> all outputs 0, no r_valid and no done afterwards; a fresh job then runs correctly.

Source files
------------

// File: rtl/systolic_mmul_engine_if.sv
// Weight, activation and result streams of the systolic matrix engine.
// master drives beats in and sinks results; slave is the engine.
interface systolic_mmul_engine_if #(
    parameter int N   = 4,
    parameter int D_W = 8,
    parameter int A_W = 32
);
    logic             w_valid;
    logic             w_ready;
    logic [N*D_W-1:0] w_data;
    logic             a_valid;
    logic             a_ready;
    logic [N*D_W-1:0] a_data;
    logic             a_last;
    logic             r_valid;
    logic [N*A_W-1:0] r_data;
    logic             r_last;

    modport master (
        output w_valid, w_data,
        output a_valid, a_data, a_last,
        input  w_ready, a_ready,
        input  r_valid, r_data, r_last
    );

    modport slave (
        input  w_valid, w_data,
        input  a_valid, a_data, a_last,
        output w_ready, a_ready,
        output r_valid, r_data, r_last
    );
endinterface

// File: rtl/systolic_mmul_engine.sv
// Weight-stationary N x N systolic matrix-vector engine.
// Rows are skewed in, partial sums flow down columns, columns are deskewed out.
module systolic_mmul_engine #(
    parameter int N      = 4,
    parameter int D_W    = 8,
    parameter int A_W    = 32,
    parameter int SIGNED = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic reuse_w_i,
    output logic busy_o,
    output logic done_o,
    systolic_mmul_engine_if.slave bus
);

    localparam int T  = 2 * N - 1;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic           wloaded_q, wloaded_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic           done_q, done_d;
    logic [T-1:0]   vld_q, lst_q;
    logic           w_acc, a_acc, r_vld;

    logic [D_W-1:0] w_q    [N][N];
    logic [A_W-1:0] ps_q   [N][N];
    logic [D_W-1:0] act_q  [N][N-1];
    logic [D_W-1:0] ain    [N][N];
    logic [A_W-1:0] pin    [N][N];
    logic [D_W-1:0] a_in   [N];
    logic [D_W-1:0] sk_out [N];
    logic [A_W-1:0] col_out[N];
    logic [N*A_W-1:0] rdat;

    function automatic logic [A_W-1:0] ext(input logic [D_W-1:0] v);
        if (SIGNED != 0) return {{(A_W-D_W){v[D_W-1]}}, v};
        return {{(A_W-D_W){1'b0}}, v};
    endfunction

    assign w_acc = bus.w_valid & bus.w_ready;
    assign a_acc = bus.a_valid & bus.a_ready;

    assign bus.w_ready = reset_i && (state_q == LOAD);
    assign bus.a_ready = reset_i && (state_q == STREAM);
    assign busy_o      = reset_i && (state_q != IDLE);
    assign done_o      = reset_i & done_q;
    assign r_vld       = reset_i & vld_q[T-1];
    assign bus.r_valid = r_vld;
    assign bus.r_last  = reset_i & lst_q[T-1];

    always_comb begin
        state_d   = state_q;
        wloaded_d = wloaded_q;
        wcnt_d    = wcnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (reuse_w_i && wloaded_q) state_d = STREAM;
                    else                        state_d = LOAD;
                end
            end
            LOAD: begin
                if (w_acc) begin
                    if (wcnt_q == CW'(N - 1)) begin
                        wcnt_d    = '0;
                        wloaded_d = 1'b1;
                        state_d   = STREAM;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (a_acc && bus.a_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (lst_q[T-1]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipe depth matches skew + array + deskew latency exactly.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            wloaded_q <= 1'b0;
            wcnt_q    <= '0;
            done_q    <= 1'b0;
            vld_q     <= '0;
            lst_q     <= '0;
        end else begin
            state_q   <= state_d;
            wloaded_q <= wloaded_d;
            wcnt_q    <= wcnt_d;
            done_q    <= done_d;
            vld_q     <= {vld_q[T-2:0], a_acc};
            lst_q     <= {lst_q[T-2:0], a_acc & bus.a_last};
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i] = a_acc ? bus.a_data[i*D_W +: D_W] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign sk_out[i] = a_in[i];
        end else begin : g_reg
            logic [D_W-1:0] sr_q [i];
            always_ff @(posedge clk_i) begin
                if (!reset_i) begin
                    for (int k = 0; k < i; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= a_in[i];
                    for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign sk_out[i] = sr_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_ain0
                assign ain[i][j] = sk_out[i];
            end else begin : g_ainn
                assign ain[i][j] = act_q[i][j-1];
            end
            if (i == 0) begin : g_pin0
                assign pin[i][j] = '0;
            end else begin : g_pinn
                assign pin[i][j] = ps_q[i-1][j];
            end
        end
    end

    // Weights shift in from column 0, so beat k settles in column N-1-k.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    w_q[i][j]  <= '0;
                    ps_q[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++) act_q[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ps_q[i][j] <= pin[i][j] + ext(ain[i][j]) * ext(w_q[i][j]);
                end
                for (int j = 0; j < N - 1; j++) act_q[i][j] <= ain[i][j];
            end
            if (w_acc) begin
                for (int i = 0; i < N; i++) begin
                    w_q[i][0] <= bus.w_data[i*D_W +: D_W];
                    for (int j = 1; j < N; j++) w_q[i][j] <= w_q[i][j-1];
                end
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_direct
            assign col_out[j] = ps_q[N-1][j];
        end else begin : g_reg
            logic [A_W-1:0] dr_q [D];
            always_ff @(posedge clk_i) begin
                if (!reset_i) begin
                    for (int k = 0; k < D; k++) dr_q[k] <= '0;
                end else begin
                    dr_q[0] <= ps_q[N-1][j];
                    for (int k = 1; k < D; k++) dr_q[k] <= dr_q[k-1];
                end
            end
            assign col_out[j] = dr_q[D-1];
        end
    end

    always_comb begin
        rdat = '0;
        if (r_vld) begin
            for (int j = 0; j < N; j++) rdat[j*A_W +: A_W] = col_out[j];
        end
    end

    assign bus.r_data = rdat;

endmodule

// File: tb/tb_systolic_mmul_engine.sv
// Bench for systolic_mmul_engine: vector table, bubbles, reuse, mid-job reset,
// randomized jobs against a matrix-product scoreboard, plus an unsigned instance.
module tb_systolic_mmul_engine;

    localparam int N = 4;
    localparam int LAT = 2 * N - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start, reuse_w, busy, done;
    logic start_u, busy_u, done_u;

    systolic_mmul_engine_if #(.N(4), .D_W(8), .A_W(32)) bif ();
    systolic_mmul_engine_if #(.N(4), .D_W(8), .A_W(32)) uif ();

    systolic_mmul_engine #(.N(4), .D_W(8), .A_W(32), .SIGNED(1)) dut (
        .clk_i(clk), .reset_i(rst_n), .start_i(start), .reuse_w_i(reuse_w),
        .busy_o(busy), .done_o(done), .bus(bif.slave)
    );

    systolic_mmul_engine #(.N(4), .D_W(8), .A_W(32), .SIGNED(0)) dut_u (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_u), .reuse_w_i(1'b0),
        .busy_o(busy_u), .done_o(done_u), .bus(uif.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_due = -1;
    bit wr_seen;
    bit wl_m;
    logic [127:0] last_r;
    byte Wm [4][4];
    logic [31:0] wb [4];
    logic [31:0] ab [$];
    bit vp [$];

    typedef struct {
        int           due;
        logic [127:0] r;
        bit           last;
    } exp_t;
    exp_t q [$];

    typedef struct {
        bit          wneg;
        logic [31:0] a;
        logic [31:0] e [4];
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [127:0] model(input logic [31:0] a);
        logic [127:0] r;
        int s;
        byte ai;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int i = 0; i < 4; i++) begin
                ai = a[i*8 +: 8];
                s += int'(ai) * int'(Wm[i][j]);
            end
            r[j*32 +: 32] = s;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            done_due = -1;
            chk("reset_ctl", {122'd0, bif.r_valid, bif.r_last, busy, done,
                              bif.w_ready, bif.a_ready}, 128'd0);
            chk("reset_rdata", bif.r_data, 128'd0);
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("r_valid", bif.r_valid, 1);
                chk("r_data", bif.r_data, q[0].r);
                chk("r_last", bif.r_last, q[0].last);
                if (q[0].last) done_due = cyc + 1;
                last_r = bif.r_data;
                void'(q.pop_front());
            end else begin
                chk("r_valid_idle", bif.r_valid, 0);
                chk("r_data_idle", bif.r_data, 128'd0);
            end
            chk("done", done, cyc == done_due);
            if (bif.w_ready) wr_seen = 1'b1;
            if (bif.a_valid && bif.a_ready)
                q.push_back('{cyc + LAT, model(bif.a_data), bif.a_last});
        end
    end

    task automatic run_job(input bit reuse, input bit pulse_start);
        int k, g, idx;
        bit acc, direct;
        direct = reuse && wl_m;
        wr_seen = 1'b0;
        start = 1'b1;
        reuse_w = reuse;
        @(posedge clk); #1;
        start = 1'b0;
        reuse_w = 1'b0;
        chk("busy_start", busy, 1);
        if (!direct) begin
            k = 0;
            g = 0;
            while (k < 4 && g < 64) begin
                bif.w_valid = ($urandom_range(0, 3) != 0);
                bif.w_data = wb[k];
                @(negedge clk);
                acc = bif.w_valid && bif.w_ready;
                @(posedge clk); #1;
                if (acc) k++;
                g++;
            end
            bif.w_valid = 1'b0;
            chk("weight_beats", k, 4);
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 4; i++) Wm[i][3-b] = wb[b][i*8 +: 8];
            wl_m = 1'b1;
        end
        idx = 0;
        for (int c = 0; c < vp.size(); c++) begin
            bif.a_valid = vp[c];
            if (vp[c]) begin
                bif.a_data = ab[idx];
                bif.a_last = (idx == ab.size() - 1);
                idx++;
            end else begin
                bif.a_data = $urandom;
                bif.a_last = 1'($urandom);
            end
            start = pulse_start && (c == 1);
            @(negedge clk);
            if (vp[c] || (c == 0 && direct)) chk("a_ready", bif.a_ready, 1);
            @(posedge clk); #1;
        end
        bif.a_valid = 1'b0;
        bif.a_last = 1'b0;
        start = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 40);
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        if (direct) chk("w_ready_on_reuse", wr_seen, 0);
        repeat (3) begin
            @(negedge clk);
            chk("stay_idle", busy, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_w(input bit neg);
        for (int b = 0; b < 4; b++) begin
            if (neg) wb[b] = 32'h80808080;
            else wb[b] = 32'h1 << (8 * (3 - b));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int cur;
        int g;
        logic [31:0] nb;
        rst_n = 1'b0;
        start = 1'b0; reuse_w = 1'b0;
        bif.w_valid = 1'b0; bif.w_data = '0;
        bif.a_valid = 1'b0; bif.a_data = '0; bif.a_last = 1'b0;
        start_u = 1'b0;
        uif.w_valid = 1'b0; uif.w_data = '0;
        uif.a_valid = 1'b0; uif.a_data = '0; uif.a_last = 1'b0;
        wl_m = 1'b0;
        last_r = '0;

        tv[0] = '{1'b0, 32'h04030201, '{1, 2, 3, 4}};
        tv[1] = '{1'b0, 32'h807F00FF, '{-1, 0, 127, -128}};
        tv[2] = '{1'b0, 32'h00000000, '{0, 0, 0, 0}};
        tv[3] = '{1'b1, 32'h80808080, '{65536, 65536, 65536, 65536}};
        tv[4] = '{1'b1, 32'h01010101, '{-512, -512, -512, -512}};
        tv[5] = '{1'b1, 32'hFF00007F, '{-16128, -16128, -16128, -16128}};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        cur = -1;
        for (int t = 0; t < 6; t++) begin
            bit reuse;
            reuse = (int'(tv[t].wneg) == cur);
            if (!reuse) begin
                set_w(tv[t].wneg);
                cur = int'(tv[t].wneg);
            end
            ab = '{tv[t].a};
            vp = '{1'b1};
            run_job(reuse, 1'b0);
            for (int j = 0; j < 4; j++)
                chk($sformatf("table%0d_lane%0d", t, j), last_r[j*32 +: 32], tv[t].e[j]);
        end

        set_w(1'b0);
        ab.delete();
        for (int b = 0; b < 5; b++) ab.push_back($urandom);
        vp = '{1, 0, 1, 1, 0, 0, 1, 1};
        run_job(1'b0, 1'b1);

        for (int jb = 0; jb < 4; jb++) begin
            for (int b = 0; b < 4; b++) wb[b] = $urandom;
            nb = $urandom_range(1, 8);
            ab.delete();
            vp.delete();
            for (int b = 0; b < int'(nb); b++) begin
                ab.push_back($urandom);
                repeat ($urandom_range(0, 2)) vp.push_back(1'b0);
                vp.push_back(1'b1);
            end
            run_job((jb > 0) && ($urandom_range(0, 1) == 1), 1'($urandom));
        end

        ab.delete();
        for (int b = 0; b < 5; b++) ab.push_back($urandom);
        start = 1'b1; reuse_w = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reuse_w = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bif.a_valid = 1'b1;
            bif.a_data = ab[b];
            bif.a_last = 1'b0;
            @(posedge clk); #1;
        end
        bif.a_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wl_m = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_due, -1);

        set_w(1'b0);
        ab = '{32'h04030201};
        vp = '{1'b1};
        run_job(1'b1, 1'b0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("post_reset_lane%0d", j), last_r[j*32 +: 32], 32'(j + 1));

        start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        uif.w_valid = 1'b1;
        uif.w_data = 32'h80808080;
        repeat (4) @(posedge clk);
        #1;
        uif.w_valid = 1'b0;
        uif.a_valid = 1'b1;
        uif.a_data = 32'h80808080;
        uif.a_last = 1'b1;
        @(negedge clk);
        chk("u_a_ready", uif.a_ready, 1);
        @(posedge clk); #1;
        uif.a_valid = 1'b0;
        uif.a_last = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!uif.r_valid && g < 20);
        chk("u_latency", g, LAT);
        chk("u_r_data", uif.r_data, {4{32'd65536}});
        chk("u_r_last", uif.r_last, 1);
        @(negedge clk);
        chk("u_done", done_u, 1);
        chk("u_busy", busy_u, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
